// File: rtl/alu_operand_sequencer_if.sv
// Switch/button inputs and registered result/status outputs between the
// board front end, the operand sequencer and the LED display stage.
interface alu_operand_sequencer_if;
    logic        BTN;
    logic [7:0]  DATA_IN;
    logic [2:0]  ALU_OP;
    logic [31:0] ALU_F;
    logic        OF;
    logic        ZF;
    logic [1:0]  STATE;
    logic [1:0]  BYTE_IDX;

    modport master (
        output BTN, DATA_IN, ALU_OP,
        input  ALU_F, OF, ZF, STATE, BYTE_IDX
    );

    modport slave (
        input  BTN, DATA_IN, ALU_OP,
        output ALU_F, OF, ZF, STATE, BYTE_IDX
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Loads two 32-bit operands LSB byte first on debounced button presses,
// runs one ALU op and holds the result and flags for the display stage.
//
// state  | meaning
// LOAD_A | each press writes DATA_IN into byte BYTE_IDX of A
// LOAD_B | each press writes DATA_IN into byte BYTE_IDX of B
// EXEC   | single cycle: sample ALU_OP, register ALU_F/OF/ZF
// SHOW   | result held; a press starts a new load at A byte 0
module alu_operand_sequencer #(
    parameter int DB_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_operand_sequencer_if.slave   bus
);
    localparam int DB = (DB_CYCLES < 1) ? 1 : DB_CYCLES;
    localparam int CW = $clog2(DB + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DB);
    localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   f_q, f_d;
    logic          of_q, of_d, zf_q, zf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press;
    logic [31:0]   alu_f;
    logic          alu_of;

    // Press fires on the sample that brings the counter to DB; saturating
    // afterwards keeps a held button from repeating.
    always_comb begin
        cnt_d = '0;
        press = 1'b0;
        if (bus.BTN) begin
            cnt_d = cnt_q;
            if (cnt_q != DB_MAX) begin
                cnt_d = cnt_q + 1'b1;
                press = (cnt_q == DB_LAST);
            end
        end
    end

    always_comb begin
        alu_f  = '0;
        alu_of = 1'b0;
        case (bus.ALU_OP)
            3'b000: alu_f = a_q & b_q;
            3'b001: alu_f = a_q | b_q;
            3'b010: alu_f = a_q ^ b_q;
            3'b011: alu_f = ~(a_q | b_q);
            3'b100: begin
                alu_f  = a_q + b_q;
                alu_of = (a_q[31] == b_q[31]) && (alu_f[31] != a_q[31]);
            end
            3'b101: begin
                alu_f  = a_q - b_q;
                alu_of = (a_q[31] != b_q[31]) && (alu_f[31] != a_q[31]);
            end
            3'b110: alu_f = {31'b0, ($signed(a_q) < $signed(b_q))};
            default: alu_f = b_q << a_q[4:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        of_d    = of_q;
        zf_d    = zf_q;
        case (state_q)
            LOAD_A: if (press) begin
                a_d[{idx_q, 3'b000} +: 8] = bus.DATA_IN;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = LOAD_B;
            end
            LOAD_B: if (press) begin
                b_d[{idx_q, 3'b000} +: 8] = bus.DATA_IN;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = EXEC;
            end
            EXEC: begin
                f_d     = alu_f;
                of_d    = alu_of;
                zf_d    = (alu_f == 32'h0);
                state_d = SHOW;
            end
            default: if (press) begin
                idx_d   = 2'd0;
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            idx_q   <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ALU_F    = f_q;
    assign bus.OF       = of_q;
    assign bus.ZF       = zf_q;
    assign bus.STATE    = state_q;
    assign bus.BYTE_IDX = idx_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: expected results go into a scoreboard queue when an op is
// issued; a monitor pops and compares whenever the sequencer enters SHOW.
module tb_alu_operand_sequencer;
    logic clk = 1'b0;
    logic rst;
    alu_operand_sequencer_if bus();

    alu_operand_sequencer #(.DB_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] f;
        logic        of_;
        logic        zf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] prev_state = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_byte(input logic [7:0] d);
        bus.DATA_IN = d;
        bus.BTN = 1'b1;
        repeat (4) cyc();
        bus.BTN = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) press_byte(w[8*i +: 8]);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] ef, input logic eof, input logic ezf);
        exp_t e;
        bit   seen;
        if (bus.STATE == 2'd3) press_byte(8'h00);
        bus.ALU_OP = op;
        e.f = ef;
        e.of_ = eof;
        e.zf = ezf;
        sb.push_back(e);
        load_word(a);
        load_word(b);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.STATE == 2'd3) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL show_timeout: STATE %0d expected 3", bus.STATE);
        end
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.STATE == 2'd3 && prev_state != 2'd3) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_show: F=%h with empty scoreboard", bus.ALU_F);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.ALU_F !== e.f || bus.OF !== e.of_ || bus.ZF !== e.zf) begin
                    n_fail++;
                    $display("FAIL result: got F=%h OF=%b ZF=%b expected F=%h OF=%b ZF=%b",
                             bus.ALU_F, bus.OF, bus.ZF, e.f, e.of_, e.zf);
                end
            end
        end
        prev_state = bus.STATE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.BTN = 1'b0;
        bus.DATA_IN = 8'h00;
        bus.ALU_OP = 3'b000;
        repeat (3) cyc();
        chk("rst_state", 32'(bus.STATE), 32'd0);
        chk("rst_idx", 32'(bus.BYTE_IDX), 32'd0);
        chk("rst_f", bus.ALU_F, 32'h0);
        chk("rst_flags", {30'b0, bus.OF, bus.ZF}, 32'h0);
        rst = 1'b0;
        cyc();

        run_op(32'h1234_5678, 32'h1234_5678, 3'b101, 32'h0000_0000, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h0000_0004, 32'h1234_5678, 3'b111, 32'h2345_6780, 1'b0, 1'b0);
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0000, 3'b011, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 3'b101, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 32'h8000_0000, 1'b1, 1'b0);

        // Result must hold while new operands are loaded.
        press_byte(8'h00);
        chk("show_exit_state", 32'(bus.STATE), 32'd0);
        chk("show_exit_idx", 32'(bus.BYTE_IDX), 32'd0);
        for (int i = 0; i < 4; i++) begin
            press_byte(8'h11);
            chk("hold_f_a", bus.ALU_F, 32'h8000_0000);
        end
        press_byte(8'h22);
        chk("hold_f_b0", bus.ALU_F, 32'h8000_0000);
        press_byte(8'h33);
        chk("hold_f_b1", bus.ALU_F, 32'h8000_0000);
        chk("hold_of", 32'(bus.OF), 32'd1);
        chk("mid_state", 32'(bus.STATE), 32'd1);
        chk("mid_idx", 32'(bus.BYTE_IDX), 32'd2);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_state", 32'(bus.STATE), 32'd0);
        chk("rst2_idx", 32'(bus.BYTE_IDX), 32'd0);
        chk("rst2_f", bus.ALU_F, 32'h0);
        chk("rst2_flags", {30'b0, bus.OF, bus.ZF}, 32'h0);

        // Debounce: a short pulse is ignored, a long hold loads exactly once.
        bus.DATA_IN = 8'hAA;
        bus.BTN = 1'b1;
        repeat (3) cyc();
        bus.BTN = 1'b0;
        cyc();
        chk("short_pulse_idx", 32'(bus.BYTE_IDX), 32'd0);
        bus.BTN = 1'b1;
        repeat (20) cyc();
        chk("long_hold_idx", 32'(bus.BYTE_IDX), 32'd1);
        bus.BTN = 1'b0;
        cyc();
        chk("long_release_idx", 32'(bus.BYTE_IDX), 32'd1);

        // Button held through reset: a full count is needed after release.
        bus.BTN = 1'b1;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (3) cyc();
        chk("held_rst_3", 32'(bus.BYTE_IDX), 32'd0);
        cyc();
        chk("held_rst_4", 32'(bus.BYTE_IDX), 32'd1);
        bus.BTN = 1'b0;
        repeat (2) cyc();

        // Partial operands were discarded: load A=3, B=5 over cleared regs.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        run_op(32'h0000_0003, 32'h0000_0005, 3'b100, 32'h0000_0008, 1'b0, 1'b0);

        repeat (2) cyc();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream stage of the LED result display. Collects two 32-bit operands byte-by-byte from 8 board switches using a debounced push-button. Executes one 3-bit ALU operation and holds ALU_F, OF and ZF registered and stable for the display stage, which selects the bytes and flags to show.

Parameters:
DB_CYCLES, 4, consecutive cycles BTN must be sampled high before one press is recognised (minimum 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
BTN  input  1  load/advance button level, already synchronised to clk
DATA_IN  input  8  operand byte from switches
ALU_OP  input  3  operation select, sampled only in EXEC
ALU_F  output  32  registered result, to display stage
OF  output  1  registered signed-overflow flag
ZF  output  1  registered zero flag
STATE  output  2  FSM state: 0 LOAD_A, 1 LOAD_B, 2 EXEC, 3 SHOW
BYTE_IDX  output  2  next byte slot to be written in LOAD_A/LOAD_B

Behaviour:
- Reset (sync, active-high) takes priority over all else:
  - STATE=LOAD_A, BYTE_IDX=0, ALU_F=0, OF=0, ZF=0.
  - Operand regs A=B=0.
  - Debounce counter=0.
- Press detect:
  - Counter increments while BTN=1 and saturates at DB_CYCLES. It clears to 0 on any cycle with BTN=0.
  - One internal `press` pulse (1 cycle) fires on the cycle the counter reaches DB_CYCLES.
  - Holding BTN produces no further presses. BTN must return low before the next press.
  - With DB_CYCLES=1, `press` fires in the first cycle BTN is sampled high.
- LOAD_A:
  - On `press`: A[8*BYTE_IDX +: 8] <= DATA_IN. The byte is taken LSB first.
  - BYTE_IDX increments. On the press that writes byte 3, BYTE_IDX wraps to 0 and STATE->LOAD_B.
- LOAD_B: identical to LOAD_A, writing B. The press that writes byte 3 moves STATE->EXEC.
- EXEC:
  - Lasts exactly 1 cycle, no press needed.
  - ALU_OP is sampled in this cycle. ALU_F/OF/ZF update at the end of the cycle, and STATE->SHOW.
  - Presses occurring during EXEC are ignored.
- SHOW:
  - ALU_F/OF/ZF are held.
  - `press` -> LOAD_A, BYTE_IDX=0.
  - A and B are retained and overwritten byte-by-byte on the next entry.
- ALU_F/OF/ZF change only in EXEC or on reset. They hold through LOAD_A/LOAD_B, so the display keeps showing the last result.
- Operations (F = result, truncated to 32 bits):
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 ADD A+B, 101 SUB A-B.
  - 110 SLT: F = {31'b0, ($signed(A) < $signed(B))}.
  - 111 SLL: F = B << A[4:0].
- OF:
  - ADD: (A[31]==B[31]) && (F[31]!=A[31]).
  - SUB: (A[31]!=B[31]) && (F[31]!=A[31]).
  - 0 for all other ops.
- ZF = (F==32'h0) for every op.
- Reset mid-load (any state) discards partial operands: A=B=0, and counting restarts at LOAD_A byte 0.
- A reset asserted while BTN is held: after release of rst, a press requires a full DB_CYCLES of BTN=1 counted from the first post-reset cycle.

Test Plan:
- DB_CYCLES=4; load A=7FFF_FFFF, B=0000_0001 (bytes FF,FF,FF,7F / 01,00,00,00), ALU_OP=100 -> SHOW, ALU_F=8000_0000, OF=1, ZF=0.
- Load A=B=1234_5678, ALU_OP=101 -> ALU_F=0, ZF=1, OF=0.
- A=FFFF_FFFF, B=0000_0001, ALU_OP=110 -> ALU_F=0000_0001, OF=0.
- A=0000_0004, B=1234_5678, ALU_OP=111 -> ALU_F=2345_6780, ZF=0.
- Debounce checks, each BTN pulse in LOAD_A:
  - BTN high 3 cycles then low -> BYTE_IDX stays 0.
  - BTN high 20 cycles -> exactly one byte loaded, BYTE_IDX=1.
- From SHOW with ALU_F=8000_0000, load 2 bytes of B, then assert rst 1 cycle:
  - Before reset: ALU_F stays 8000_0000 throughout the loading.
  - After reset: STATE=0, BYTE_IDX=0, ALU_F=0, OF=0, ZF=0.
